// File: rtl/frame_to_sdram_writer.sv
// Purpose: loads one frame of 8-bit pixels into SDRAM as 16-bit words at {frame, line, word}.
// Latency: oWR_EN rises 1 cycle after the high byte is accepted; at most one word per 3 cycles.
// Backpressure: oPIX_READY is low while a write is pending; writes hold until iWAIT_REQUEST drops.
// Ports: iCLK/iRST clock and async reset; iSTART/iFRAME_ID/iABORT frame control;
//        iPIX_DATA/iPIX_VALID/oPIX_READY pixel stream; iWAIT_REQUEST/oWR_EN/oWR_ADDR/oWR_DATA
//        Avalon-style write master; oBUSY frame in progress; oDONE last-word pulse.
module frame_to_sdram_writer #(
  parameter int H_PIXELS = 1024,
  parameter int V_LINES  = 768
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [5:0]  iFRAME_ID,
  input  logic        iABORT,
  input  logic [7:0]  iPIX_DATA,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  input  logic        iWAIT_REQUEST,
  output logic        oWR_EN,
  output logic [24:0] oWR_ADDR,
  output logic [15:0] oWR_DATA,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [8:0] WORD_LAST = 9'(H_PIXELS / 2 - 1);
  localparam logic [9:0] LINE_LAST = 10'(V_LINES - 1);

  logic [2:0]  r_state;
  logic [5:0]  r_frame;
  logic [9:0]  r_line;
  logic [8:0]  r_word;
  logic [7:0]  r_low;
  logic        r_wr_en;
  logic [24:0] r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_abort;   // abort seen while a write was outstanding

  logic w_accept;
  logic w_wr_done;

  // Ready is purely a function of state so it never loops back through iPIX_VALID.
  assign oPIX_READY = (r_state == S_LO) || (r_state == S_HI);
  assign oBUSY      = (r_state != S_IDLE);
  assign oDONE      = (r_state == S_FIN);
  assign oWR_EN     = r_wr_en;
  assign oWR_ADDR   = r_wr_addr;
  assign oWR_DATA   = r_wr_data;

  assign w_accept  = iPIX_VALID && oPIX_READY;
  assign w_wr_done = r_wr_en && !iWAIT_REQUEST;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_line    <= '0;
      r_word    <= '0;
      r_low     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_abort   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Abort wins over a simultaneous start.
          if (iSTART && !iABORT) begin
            r_frame <= iFRAME_ID;
            r_line  <= '0;
            r_word  <= '0;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (iABORT) begin
            r_low   <= '0;
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_low   <= iPIX_DATA;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (iABORT) begin
            r_low   <= '0;
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_wr_data <= {iPIX_DATA, r_low};
            r_wr_addr <= {r_frame, r_line, r_word};
            r_wr_en   <= 1'b1;
            r_abort   <= 1'b0;
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          // A posted write is never withdrawn; an abort waits for completion.
          if (iABORT) begin
            r_abort <= 1'b1;
          end
          if (w_wr_done) begin
            r_wr_en <= 1'b0;
            r_abort <= 1'b0;
            if (r_abort || iABORT) begin
              r_state <= S_IDLE;
            end else if (r_word != WORD_LAST) begin
              r_word  <= r_word + 9'd1;
              r_state <= S_LO;
            end else begin
              r_word <= '0;
              if (r_line != LINE_LAST) begin
                r_line  <= r_line + 10'd1;
                r_state <= S_LO;
              end else begin
                r_state <= S_FIN;
              end
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
